jsv_sdram_arbiter: RTL and testbench
====================================

JSV_SDRAM_ARBITER -- requirements
Module: jsv_sdram_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of client channels, legal 2..4.
REQ-002 SHALL have parameter ADDR_W, default 23, word address width.
REQ-003 SHALL have parameter DATA_W, default 16, data width, multiple of 8; BE_W = DATA_W/8.
REQ-004 SHALL have parameter LEN_W, default 4, burst length field width; burst beats = cli_len+1.
REQ-005 SHALL have parameter PRIO_MODE, default 0; 0 = round-robin, 1 = fixed priority with channel 0 highest.
REQ-006 SHALL have parameter TIMEOUT, default 255, maximum cycles one beat may wait for acknowledge.
REQ-007 One clock, clk_clk; reset is asynchronous and active-low on reset_reset_n.
REQ-008 Ports, in order:
- clk_clk  in  1  clock
- reset_reset_n  in  1  async active-low reset
- cli_req  in  NUM_CH  per-channel request, level
- cli_we  in  NUM_CH  1 = write burst
- cli_addr  in  NUM_CH*ADDR_W  burst start address
- cli_be  in  NUM_CH*BE_W  byte enables, held for the whole burst
- cli_len  in  NUM_CH*LEN_W  beats minus one
- cli_wdata  in  NUM_CH*DATA_W  current write beat data
- cli_grant  out  NUM_CH  one-cycle pulse, burst accepted
- cli_ack  out  NUM_CH  one-cycle pulse per completed beat
- cli_err  out  NUM_CH  one-cycle pulse, burst aborted on timeout
- cli_rdata  out  DATA_W  read data, valid with cli_ack
- bridge_address  out  ADDR_W
- bridge_byte_enable  out  BE_W
- bridge_read  out  1
- bridge_write  out  1
- bridge_write_data  out  DATA_W
- bridge_acknowledge  in  1
- bridge_read_data  in  DATA_W

Function
REQ-009 States SHALL be IDLE, BEAT and NEXT.
REQ-010 IDLE: when any cli_req is high, SHALL select a winner, pulse its cli_grant, latch its we/addr/be/len/wdata and enter BEAT on the next cycle.
REQ-011 Round-robin SHALL search upward from the channel after the last granted one, wrapping at NUM_CH; after reset the pointer SHALL favour channel 0.
REQ-012 Fixed priority SHALL grant the lowest-index requester.
REQ-013 BEAT SHALL drive bridge_read = !we or bridge_write = we, never both, with the latched address, byte enables and data held stable until bridge_acknowledge.
REQ-014 On bridge_acknowledge in BEAT: strobes SHALL drop on the next cycle, the owner's cli_ack SHALL pulse in that same next cycle, and cli_rdata SHALL be registered from bridge_read_data.
REQ-015 After the last beat SHALL go to IDLE; otherwise SHALL go to NEXT.
REQ-016 NEXT (one cycle): address SHALL increment by 1, wrapping modulo 2^ADDR_W; the beat counter SHALL increment; cli_wdata SHALL be re-latched; then SHALL enter BEAT.
REQ-017 Client SHALL present the next write beat on cli_wdata in the cycle cli_ack pulses; the arbiter SHALL sample it in NEXT.
REQ-018 Beat wait counter SHALL clear on BEAT entry. If TIMEOUT cycles elapse without acknowledge, SHALL drop strobes, pulse the owner's cli_err instead of cli_ack, abandon the remaining beats and return to IDLE.
REQ-019 cli_req SHALL be ignored outside IDLE; deasserting the owner's request mid-burst SHALL NOT abort the burst.
REQ-020 bridge_acknowledge outside BEAT SHALL be ignored.
REQ-021 A new grant SHALL occur no earlier than the cycle after returning to IDLE; there is no back-to-back overlap.

Reset
REQ-022 Reset asserted SHALL force IDLE; clear all cli_grant/cli_ack/cli_err, bridge_read, bridge_write, bridge_address, bridge_byte_enable, bridge_write_data, cli_rdata and counters to 0; and set the round-robin pointer so channel 0 wins next. This SHALL apply mid-burst without completing the burst.

Verification
REQ-023 Ch1 read, addr 0x000100, len 3, ack 2 cycles after each strobe, rdata 0xA000+beat -> 4 cli_ack[1] pulses, addresses 0x100..0x103, cli_rdata 0xA000..0xA003.
REQ-024 PRIO_MODE 0, ch0 and ch1 requesting continuously with len 0 -> grants alternate 0,1,0,1; PRIO_MODE 1 -> ch0 always wins.
REQ-025 Ch0 write, addr 0x7FFFFF, len 1, wdata 0x1234 then 0x5678 -> bridge sees 0x7FFFFF/0x1234 then 0x000000/0x5678.
REQ-026 TIMEOUT 8, no acknowledge -> strobe high for exactly 8 cycles, cli_err[0] pulses once, no cli_ack, state returns to IDLE.
REQ-027 Reset asserted during beat 2 of a 4-beat write -> bridge_write low asynchronously, all outputs 0; after release, a pending ch1 request loses to a ch0 request.
REQ-028 Spurious bridge_acknowledge in IDLE -> no cli_ack and no state change.

Source files
------------

// File: rtl/jsv_sdram_arbiter.sv
// Multi-channel burst arbiter in front of a single-beat SDRAM bridge.
// Winner is latched in IDLE, each beat is strobed in BEAT, and NEXT advances address and data.
module jsv_sdram_arbiter #(
  parameter int NUM_CH    = 2,
  parameter int ADDR_W    = 23,
  parameter int DATA_W    = 16,
  parameter int LEN_W     = 4,
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 255
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset_n,
  input  logic [NUM_CH-1:0]          cli_req,
  input  logic [NUM_CH-1:0]          cli_we,
  input  logic [NUM_CH*ADDR_W-1:0]   cli_addr,
  input  logic [NUM_CH*DATA_W/8-1:0] cli_be,
  input  logic [NUM_CH*LEN_W-1:0]    cli_len,
  input  logic [NUM_CH*DATA_W-1:0]   cli_wdata,
  output logic [NUM_CH-1:0]          cli_grant,
  output logic [NUM_CH-1:0]          cli_ack,
  output logic [NUM_CH-1:0]          cli_err,
  output logic [DATA_W-1:0]          cli_rdata,
  output logic [ADDR_W-1:0]          bridge_address,
  output logic [DATA_W/8-1:0]        bridge_byte_enable,
  output logic                       bridge_read,
  output logic                       bridge_write,
  output logic [DATA_W-1:0]          bridge_write_data,
  input  logic                       bridge_acknowledge,
  input  logic [DATA_W-1:0]          bridge_read_data
);
  localparam int BE_W = DATA_W / 8;
  localparam int CH_W = $clog2(NUM_CH);
  localparam int TW   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BEAT, NEXT} state_t;
  state_t state, state_nx;

  logic [CH_W-1:0]   last, owner, win, sel;
  logic              found;
  logic              we_q;
  logic [LEN_W-1:0]  len_q, beat_cnt;
  logic [TW-1:0]     wait_cnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [BE_W-1:0]   sel_be;
  logic [LEN_W-1:0]  sel_len;
  logic [DATA_W-1:0] sel_wdata;
  logic              start, acked, timeout;

  // Round-robin: first requester above the last grant, else wrap to the lowest index.
  always_comb begin
    win   = '0;
    found = 1'b0;
    if (PRIO_MODE == 0) begin
      for (int j = 0; j < NUM_CH; j++)
        if (!found && cli_req[j] && CH_W'(j) > last) begin
          win   = CH_W'(j);
          found = 1'b1;
        end
    end
    for (int j = 0; j < NUM_CH; j++)
      if (!found && cli_req[j]) begin
        win   = CH_W'(j);
        found = 1'b1;
      end
  end

  always_comb begin
    sel       = (state == IDLE) ? win : owner;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_be    = '0;
    sel_len   = '0;
    sel_wdata = '0;
    for (int j = 0; j < NUM_CH; j++)
      if (sel == CH_W'(j)) begin
        sel_we    = cli_we[j];
        sel_addr  = cli_addr[j*ADDR_W +: ADDR_W];
        sel_be    = cli_be[j*BE_W +: BE_W];
        sel_len   = cli_len[j*LEN_W +: LEN_W];
        sel_wdata = cli_wdata[j*DATA_W +: DATA_W];
      end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) state <= IDLE;
    else                state <= state_nx;

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    acked    = 1'b0;
    timeout  = 1'b0;
    case (state)
      IDLE: if (|cli_req) begin
        start    = 1'b1;
        state_nx = BEAT;
      end
      BEAT: if (bridge_acknowledge) begin
        acked    = 1'b1;
        state_nx = (beat_cnt == len_q) ? IDLE : NEXT;
      end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
        timeout  = 1'b1;
        state_nx = IDLE;
      end
      NEXT:    state_nx = BEAT;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      last               <= CH_W'(NUM_CH - 1);
      owner              <= '0;
      we_q               <= 1'b0;
      len_q              <= '0;
      beat_cnt           <= '0;
      wait_cnt           <= '0;
      cli_grant          <= '0;
      cli_ack            <= '0;
      cli_err            <= '0;
      cli_rdata          <= '0;
      bridge_address     <= '0;
      bridge_byte_enable <= '0;
      bridge_read        <= 1'b0;
      bridge_write       <= 1'b0;
      bridge_write_data  <= '0;
    end else begin
      cli_grant <= '0;
      cli_ack   <= '0;
      cli_err   <= '0;
      if (start) begin
        owner              <= win;
        last               <= win;
        cli_grant          <= NUM_CH'(1) << win;
        we_q               <= sel_we;
        len_q              <= sel_len;
        beat_cnt           <= '0;
        wait_cnt           <= '0;
        bridge_address     <= sel_addr;
        bridge_byte_enable <= sel_be;
        bridge_write_data  <= sel_wdata;
        bridge_read        <= !sel_we;
        bridge_write       <= sel_we;
      end
      if (state == BEAT && !acked && !timeout)
        wait_cnt <= wait_cnt + TW'(1);
      if (acked || timeout) begin
        bridge_read  <= 1'b0;
        bridge_write <= 1'b0;
      end
      if (acked) begin
        cli_ack   <= NUM_CH'(1) << owner;
        cli_rdata <= bridge_read_data;
      end
      if (timeout)
        cli_err <= NUM_CH'(1) << owner;
      if (state == NEXT) begin
        bridge_address    <= bridge_address + ADDR_W'(1);
        beat_cnt          <= beat_cnt + LEN_W'(1);
        bridge_write_data <= sel_wdata;
        wait_cnt          <= '0;
        bridge_read       <= !we_q;
        bridge_write      <= we_q;
      end
    end
  end
endmodule

// File: tb/tb_jsv_sdram_arbiter.sv
// Bench for jsv_sdram_arbiter: table of bursts checked against a beat scoreboard,
// plus arbitration, timeout, mid-burst reset and stray-acknowledge sequences.
module tb_jsv_sdram_arbiter;
  logic        clk_clk = 0;
  logic        reset_reset_n;
  logic [1:0]  cli_req, cli_we;
  logic [45:0] cli_addr;
  logic [3:0]  cli_be;
  logic [7:0]  cli_len;
  logic [31:0] cli_wdata;
  logic [1:0]  cli_grant, cli_ack, cli_err;
  logic [15:0] cli_rdata;
  logic [22:0] bridge_address;
  logic [1:0]  bridge_byte_enable;
  logic        bridge_read, bridge_write;
  logic [15:0] bridge_write_data, bridge_read_data;
  logic        ack_r, spur_ack;
  logic [1:0]  fp_grant, fp_ack, fp_err;
  logic [15:0] fp_rdata, fp_wdata;
  logic [22:0] fp_addr;
  logic [1:0]  fp_be;
  logic        fp_read, fp_write;

  always #5 clk_clk = ~clk_clk;

  jsv_sdram_arbiter #(.PRIO_MODE(0), .TIMEOUT(8)) u_rr (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .cli_req(cli_req), .cli_we(cli_we), .cli_addr(cli_addr), .cli_be(cli_be),
    .cli_len(cli_len), .cli_wdata(cli_wdata),
    .cli_grant(cli_grant), .cli_ack(cli_ack), .cli_err(cli_err), .cli_rdata(cli_rdata),
    .bridge_address(bridge_address), .bridge_byte_enable(bridge_byte_enable),
    .bridge_read(bridge_read), .bridge_write(bridge_write),
    .bridge_write_data(bridge_write_data),
    .bridge_acknowledge(ack_r | spur_ack), .bridge_read_data(bridge_read_data));

  jsv_sdram_arbiter #(.PRIO_MODE(1), .TIMEOUT(8)) u_fp (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .cli_req(cli_req), .cli_we(cli_we), .cli_addr(cli_addr), .cli_be(cli_be),
    .cli_len(cli_len), .cli_wdata(cli_wdata),
    .cli_grant(fp_grant), .cli_ack(fp_ack), .cli_err(fp_err), .cli_rdata(fp_rdata),
    .bridge_address(fp_addr), .bridge_byte_enable(fp_be),
    .bridge_read(fp_read), .bridge_write(fp_write),
    .bridge_write_data(fp_wdata),
    .bridge_acknowledge(ack_r | spur_ack), .bridge_read_data(bridge_read_data));

  typedef struct {
    int          ch;
    bit          we;
    logic [22:0] addr;
    logic [3:0]  len;
    logic [15:0] wbase, wstep, rbase;
    logic [1:0]  be;
  } vec_t;

  typedef struct {
    logic [22:0] addr;
    bit          we;
    logic [15:0] data;
    logic [1:0]  be;
  } beat_t;

  beat_t       exp_q[$];
  int          total = 0, bad = 0;
  bit          resp_on = 0, chk_beats = 0;
  int          resp_dly = 2, cnt = 0;
  logic [15:0] rd_base = 0, rd_idx = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bridge model: acknowledges each strobe resp_dly negedges after it appears.
  initial begin
    beat_t e;
    ack_r = 0;
    bridge_read_data = 0;
    forever begin
      @(negedge clk_clk);
      if (!reset_reset_n) begin
        ack_r = 0; cnt = 0;
      end else if (ack_r) begin
        ack_r = 0; cnt = 0;
      end else if (resp_on && (bridge_read || bridge_write)) begin
        cnt++;
        if (cnt >= resp_dly) begin
          if (chk_beats) begin
            if (exp_q.size() == 0) begin
              total++; bad++;
              $display("FAIL beat_extra: got addr %h expected no beat", bridge_address);
            end else begin
              e = exp_q.pop_front();
              chk("beat_addr", 32'(bridge_address), 32'(e.addr));
              chk("beat_strobe", {30'd0, bridge_read, bridge_write}, e.we ? 32'd1 : 32'd2);
              chk("beat_be", 32'(bridge_byte_enable), 32'(e.be));
              if (e.we) chk("beat_wdata", 32'(bridge_write_data), 32'(e.data));
            end
          end
          bridge_read_data = rd_base + rd_idx;
          rd_idx++;
          ack_r = 1;
        end
      end
    end
  end

  task automatic set_ch(input int ch, input bit we, input logic [22:0] a,
                        input logic [3:0] len, input logic [15:0] wd, input logic [1:0] be);
    cli_we[ch]              = we;
    cli_addr[ch*23 +: 23]   = a;
    cli_len[ch*4 +: 4]      = len;
    cli_wdata[ch*16 +: 16]  = wd;
    cli_be[ch*2 +: 2]       = be;
  endtask

  task automatic wait_grant(input string name, input logic [1:0] exp);
    int n = 0;
    do begin @(negedge clk_clk); n++; end while (cli_grant == 0 && n < 30);
    chk(name, 32'(cli_grant), 32'(exp));
  endtask

  task automatic do_burst(input vec_t v);
    beat_t b;
    int acks = 0;
    for (int i = 0; i <= int'(v.len); i++) begin
      b.addr = v.addr + 23'(i);
      b.we   = v.we;
      b.data = v.wbase + 16'(i) * v.wstep;
      b.be   = v.be;
      exp_q.push_back(b);
    end
    rd_base = v.rbase; rd_idx = 0;
    chk_beats = 1; resp_on = 1; resp_dly = 2;
    @(negedge clk_clk);
    set_ch(v.ch, v.we, v.addr, v.len, v.wbase, v.be);
    cli_req[v.ch] = 1;
    wait_grant("burst_grant", 2'(1 << v.ch));
    cli_req[v.ch] = 0;
    for (int n = 0; n < 200 && acks <= int'(v.len); n++) begin
      @(negedge clk_clk);
      if (cli_err != 0) chk("burst_err", 32'(cli_err), 0);
      if (cli_ack[v.ch]) begin
        if (!v.we) chk("burst_rdata", 32'(cli_rdata), 32'(v.rbase + 16'(acks)));
        acks++;
        cli_wdata[v.ch*16 +: 16] = v.wbase + 16'(acks) * v.wstep;
      end
    end
    chk("burst_acks", acks, int'(v.len) + 1);
    chk("burst_q_empty", exp_q.size(), 0);
    exp_q.delete();
    chk_beats = 0;
    repeat (2) @(negedge clk_clk);
  endtask

  initial begin
    vec_t vt[4];
    logic [1:0] exp_g[4];
    int hi, errs, acks, n;
    vt[0] = '{1, 1'b0, 23'h000100, 4'd3, 16'h0000, 16'h0000, 16'hA000, 2'b11};
    vt[1] = '{0, 1'b1, 23'h7FFFFF, 4'd1, 16'h1234, 16'h4444, 16'h0000, 2'b11};
    vt[2] = '{0, 1'b0, 23'h000200, 4'd0, 16'h0000, 16'h0000, 16'h5500, 2'b01};
    vt[3] = '{1, 1'b1, 23'h7FFFFE, 4'd2, 16'h0F00, 16'h0101, 16'h0000, 2'b10};
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};

    reset_reset_n = 0; spur_ack = 0;
    cli_req = 0; cli_we = 0; cli_addr = 0; cli_be = 0; cli_len = 0; cli_wdata = 0;
    repeat (3) @(negedge clk_clk);
    chk("rst_grant", 32'(cli_grant), 0);
    chk("rst_ack_err", {cli_ack, cli_err}, 0);
    chk("rst_strobes", {bridge_read, bridge_write}, 0);
    chk("rst_addr", 32'(bridge_address), 0);
    chk("rst_data", {bridge_write_data, cli_rdata}, 0);
    reset_reset_n = 1;
    repeat (2) @(negedge clk_clk);

    foreach (vt[i]) do_burst(vt[i]);

    // Both channels request continuously with single-beat reads.
    resp_on = 1; resp_dly = 1;
    set_ch(0, 0, 23'h10, 0, 0, 2'b11);
    set_ch(1, 0, 23'h20, 0, 0, 2'b11);
    cli_req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin @(negedge clk_clk); n++; end while (cli_grant == 0 && n < 30);
      chk("rr_grant", 32'(cli_grant), 32'(exp_g[k]));
      chk("fp_grant", 32'(fp_grant), 32'd1);
    end
    cli_req = 0;
    repeat (8) @(negedge clk_clk);

    // No acknowledge: strobe must time out after exactly 8 cycles.
    resp_on = 0;
    set_ch(0, 0, 23'h40, 0, 0, 2'b11);
    cli_req[0] = 1;
    wait_grant("to_grant", 2'b01);
    cli_req[0] = 0;
    hi = bridge_read; errs = 0; acks = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_clk);
      if (bridge_read) hi++;
      if (cli_err[0]) errs++;
      if (cli_ack != 0) acks++;
    end
    chk("to_strobe_cycles", hi, 8);
    chk("to_err_pulses", errs, 1);
    chk("to_no_ack", acks, 0);

    // Reset during beat 2 of a 4-beat write.
    resp_on = 1; resp_dly = 2;
    set_ch(0, 1, 23'h300, 3, 16'hBEEF, 2'b11);
    cli_req[0] = 1;
    wait_grant("mr_grant", 2'b01);
    cli_req[0] = 0;
    n = 0;
    do begin @(negedge clk_clk); n++; end while (!cli_ack[0] && n < 40);
    chk("mr_first_ack", 32'(cli_ack), 32'd1);
    n = 0;
    do begin @(negedge clk_clk); n++; end while (!bridge_write && n < 40);
    chk("mr_beat2_strobe", 32'(bridge_write), 1);
    #1 reset_reset_n = 0;
    #1;
    chk("mr_strobes", {bridge_read, bridge_write}, 0);
    chk("mr_addr_be", {bridge_address, bridge_byte_enable}, 0);
    chk("mr_outs", {cli_grant, cli_ack, cli_err, bridge_write_data}, 0);
    chk("mr_rdata", 32'(cli_rdata), 0);
    set_ch(0, 0, 23'h50, 0, 0, 2'b11);
    set_ch(1, 0, 23'h60, 0, 0, 2'b11);
    cli_req = 2'b11;
    @(negedge clk_clk);
    reset_reset_n = 1;
    wait_grant("mr_post_grant", 2'b01);
    cli_req = 0;
    repeat (10) @(negedge clk_clk);

    // Stray acknowledge while idle.
    resp_on = 0;
    @(negedge clk_clk); spur_ack = 1;
    @(negedge clk_clk); spur_ack = 0;
    acks = 0; hi = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_clk);
      if (cli_ack != 0 || cli_grant != 0) acks++;
      if (bridge_read || bridge_write) hi++;
    end
    chk("spur_no_ack", acks, 0);
    chk("spur_no_strobe", hi, 0);
    do_burst(vt[2]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
